// File: rtl/bp_resolve_queue_if.sv
// Handshake bundle between IF/WB and the branch-prediction resolve queue.
// master = pipeline side driving enqueues/resolves, slave = the queue itself.
interface bp_resolve_queue_if #(parameter int DEPTH = 8);
    localparam int PTR_W = $clog2(DEPTH);

    logic             enq;
    logic [31:0]      enq_pc;
    logic [31:0]      enq_pred_pc;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             resolve;
    logic [31:0]      resolve_pc;
    logic [31:0]      resolve_next_pc;
    logic             ext_flush;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic             order_err;
    logic [31:0]      resolved_cnt;
    logic [31:0]      mispred_cnt;

    modport master (
        output enq, enq_pc, enq_pred_pc, resolve, resolve_pc, resolve_next_pc, ext_flush,
        input  full, empty, count, mispredict, redirect_pc, order_err, resolved_cnt, mispred_cnt
    );

    modport slave (
        input  enq, enq_pc, enq_pred_pc, resolve, resolve_pc, resolve_next_pc, ext_flush,
        output full, empty, count, mispredict, redirect_pc, order_err, resolved_cnt, mispred_cnt
    );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-order queue of IF predictions, checked against actual next PC at WB retire.
// A wrong prediction pulses mispredict/redirect_pc one cycle later and flushes the queue.
module bp_resolve_queue #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    bp_resolve_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   cnt;
    logic             misp_q, oerr_q;
    logic [31:0]      redir_q, rcnt_q, mcnt_q;

    logic   full, empty;
    entry_t head_ent;
    logic   res_acc, enq_acc, miss, flush_now, oerr_set;

    assign full      = (cnt == (PTR_W+1)'(DEPTH));
    assign empty     = (cnt == '0);
    assign head_ent  = mem[head];
    assign res_acc   = bus.resolve && !empty;
    assign miss      = res_acc && (head_ent.pred_pc != bus.resolve_next_pc);
    assign flush_now = bus.ext_flush || miss;
    // Full blocks enq even when a resolve frees a slot this cycle (no bypass).
    assign enq_acc   = bus.enq && !full && !flush_now;
    assign oerr_set  = (bus.resolve && empty) || (res_acc && (head_ent.pc != bus.resolve_pc));

    always_ff @(posedge clk) begin
        if (enq_acc) mem[tail] <= '{pc: bus.enq_pc, pred_pc: bus.enq_pred_pc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            misp_q  <= 1'b0;
            redir_q <= '0;
            oerr_q  <= 1'b0;
            rcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            misp_q <= miss;
            if (miss) redir_q <= bus.resolve_next_pc;
            if (oerr_set) oerr_q <= 1'b1;
            if (res_acc && rcnt_q != '1) rcnt_q <= rcnt_q + 32'd1;
            if (miss && mcnt_q != '1) mcnt_q <= mcnt_q + 32'd1;

            if (flush_now) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (res_acc) head <= head + PTR_W'(1);
                if (enq_acc) tail <= tail + PTR_W'(1);
                case ({enq_acc, res_acc})
                    2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                    2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = cnt;
    assign bus.mispredict   = misp_q;
    assign bus.redirect_pc  = redir_q;
    assign bus.order_err    = oerr_q;
    assign bus.resolved_cnt = rcnt_q;
    assign bus.mispred_cnt  = mcnt_q;
endmodule

// File: tb/tb_bp_resolve_queue.sv
// Random + directed bench for bp_resolve_queue against a queue-based reference model.
module tb_bp_resolve_queue;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bp_resolve_queue_if #(.DEPTH(DEPTH)) bus ();
    bp_resolve_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    ent_t        mq[$];
    logic        m_misp, m_oerr;
    logic [31:0] m_redir, m_rcnt, m_mcnt;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":count"}, 32'(bus.count), 32'(mq.size()));
        chk({tag, ":empty"}, 32'(bus.empty), 32'(mq.size() == 0));
        chk({tag, ":full"}, 32'(bus.full), 32'(mq.size() == DEPTH));
        chk({tag, ":misp"}, 32'(bus.mispredict), 32'(m_misp));
        chk({tag, ":redir"}, bus.redirect_pc, m_redir);
        chk({tag, ":oerr"}, 32'(bus.order_err), 32'(m_oerr));
        chk({tag, ":rcnt"}, bus.resolved_cnt, m_rcnt);
        chk({tag, ":mcnt"}, bus.mispred_cnt, m_mcnt);
    endtask

    task automatic model_clear();
        mq.delete();
        m_misp = 0; m_oerr = 0; m_redir = 0; m_rcnt = 0; m_mcnt = 0;
    endtask

    // One clock: drive inputs, advance model, check outputs after the edge.
    task automatic cyc(input string tag, input logic e, input logic [31:0] epc, input logic [31:0] epred,
                       input logic r, input logic [31:0] rpc, input logic [31:0] rnext, input logic xf);
        bit was_full, flush, miss;
        bus.enq = e; bus.enq_pc = epc; bus.enq_pred_pc = epred;
        bus.resolve = r; bus.resolve_pc = rpc; bus.resolve_next_pc = rnext;
        bus.ext_flush = xf;
        was_full = (mq.size() == DEPTH);
        flush = xf;
        miss = 0;
        if (r && mq.size() == 0) m_oerr = 1;
        if (r && mq.size() > 0) begin
            if (mq[0].pc != rpc) m_oerr = 1;
            if (m_rcnt != 32'hFFFF_FFFF) m_rcnt++;
            if (mq[0].pred != rnext) begin
                miss = 1;
                flush = 1;
                if (m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
                m_redir = rnext;
            end else begin
                void'(mq.pop_front());
            end
        end
        m_misp = miss;
        if (flush) mq.delete();
        else if (e && !was_full) mq.push_back('{pc: epc, pred: epred});
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic enq1(input string tag, input logic [31:0] pc);
        cyc(tag, 1, pc, pc + 32'd4, 0, 0, 0, 0);
    endtask

    task automatic res_hit(input string tag);
        cyc(tag, 0, 0, 0, 1, mq[0].pc, mq[0].pred, 0);
    endtask

    task automatic do_reset();
        bus.enq = 0; bus.resolve = 0; bus.ext_flush = 0;
        #2;
        rst = 0;
        #1;
        model_clear();
        // Async: outputs must be cleared before any clock edge.
        chk("rst:count", 32'(bus.count), 0);
        chk("rst:empty", 32'(bus.empty), 1);
        chk("rst:misp", 32'(bus.mispredict), 0);
        chk("rst:rcnt", bus.resolved_cnt, 0);
        chk("rst:mcnt", bus.mispred_cnt, 0);
        chk("rst:oerr", 32'(bus.order_err), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.enq = 0; bus.enq_pc = 0; bus.enq_pred_pc = 0;
        bus.resolve = 0; bus.resolve_pc = 0; bus.resolve_next_pc = 0; bus.ext_flush = 0;
        model_clear();
        #12;
        rst = 1;
        @(posedge clk);
        #1;
        check_all("init");

        // Mid-stream async reset with counters and entries populated.
        enq1("pre", 32'h80); res_hit("pre");
        enq1("pre", 32'h90); enq1("pre", 32'h94); enq1("pre", 32'h98);
        do_reset();

        // All hits.
        enq1("hit", 32'h100); enq1("hit", 32'h104); enq1("hit", 32'h108);
        res_hit("hit"); res_hit("hit"); res_hit("hit");
        chk("hit:rcnt3", bus.resolved_cnt, 32'd3);

        // Miss with younger entries and a same-cycle enqueue.
        enq1("miss", 32'h200); enq1("miss", 32'h208); enq1("miss", 32'h210);
        cyc("miss", 1, 32'h500, 32'h504, 1, 32'h200, 32'h300, 0);
        chk("miss:redir300", bus.redirect_pc, 32'h300);
        idle("miss_after");

        // Full, blocked enq, no bypass on simultaneous resolve, pointer wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) enq1("fill", 32'h1000 + 32'(i) * 4);
        enq1("ovf", 32'h2000);
        cyc("nobyp", 1, 32'h2100, 32'h2104, 1, mq[0].pc, mq[0].pred, 0);
        enq1("wrap", 32'h2200);
        while (mq.size() > 0) res_hit("drain");

        // Order errors.
        cyc("oerr_empty", 0, 0, 0, 1, 32'h10, 32'h14, 0);
        idle("oerr_sticky");
        do_reset();
        enq1("oerr_pc", 32'h400);
        cyc("oerr_pc", 0, 0, 0, 1, 32'h404, 32'h404, 0);

        // External flush alone, then coincident with a miss.
        do_reset();
        for (int i = 0; i < 5; i++) enq1("xf", 32'h600 + 32'(i) * 4);
        cyc("xf", 1, 32'h700, 32'h704, 0, 0, 0, 1);
        enq1("xfm", 32'h800);
        cyc("xfm", 0, 0, 0, 1, 32'h800, 32'h900, 1);
        idle("xfm_after");

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic        e, r, xf;
            logic [31:0] epc, epred, rpc, rnext;
            e = ($urandom_range(0, 2) != 0);
            epc = $urandom & 32'hFFFF_FFFC;
            epred = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : epc + 32'd4;
            r = ($urandom_range(0, 2) == 0);
            xf = ($urandom_range(0, 29) == 0);
            if (mq.size() > 0) begin
                rpc = ($urandom_range(0, 49) == 0) ? mq[0].pc + 32'd8 : mq[0].pc;
                rnext = ($urandom_range(0, 7) == 0) ? mq[0].pred ^ 32'h40 : mq[0].pred;
            end else begin
                rpc = $urandom;
                rnext = $urandom;
                if ($urandom_range(0, 9) != 0) r = 0;
            end
            cyc("rand", e, epc, epred, r, rpc, rnext, xf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
- Sits directly downstream of the branch predictor, between the IF stage and writeback.
- Records every IF-stage prediction (fetch PC plus predicted next PC) in order. When each instruction retires at WB, it compares the predicted next PC with the actual next PC.
- On a mismatch it raises a one-cycle registered mispredict/redirect to the PC mux and flushes all younger predictions.
- Keeps saturating resolve/mispredict counters for performance counters.

Parameters:
- DEPTH, 8, number of in-flight prediction entries; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous and active-low (0 = reset).
- enq  in  1  IF stage issues a fetched instruction this cycle.
- enq_pc  in  32  fetch PC (if_pc).
- enq_pred_pc  in  32  predicted next PC (if_pred_pc).
- full  out  1  count == DEPTH; IF must stall.
- empty  out  1  count == 0.
- count  out  PTR_W+1  number of valid entries.
- resolve  in  1  WB retires a valid instruction (load_buffers && wb_pkt.valid).
- resolve_pc  in  32  wb_pkt.data.pc.
- resolve_next_pc  in  32  wb_pkt.data.next_pc.
- ext_flush  in  1  external flush (trap/exception); drops all entries.
- mispredict  out  1  registered one-cycle pulse requesting redirect.
- redirect_pc  out  32  correct PC; valid when mispredict=1, otherwise holds its last value.
- order_err  out  1  sticky: resolve with empty queue, or head PC != resolve_pc.
- resolved_cnt  out  32  saturating count of accepted resolves.
- mispred_cnt  out  32  saturating count of mispredicts.

Behaviour:
- Reset (async assert, sync release): head=tail=0, count=0, mispredict=0, redirect_pc=0, order_err=0, both counters=0. Entry storage is not reset. Reset mid-operation discards every entry immediately.
- Storage: circular buffer of {pc, pred_pc}. head = oldest entry, tail = next free slot. Pointers wrap modulo DEPTH (DEPTH-1 → 0).
- Enqueue accepted iff enq && !full && !flush_now. Accepted enqueue writes entry[tail] and increments tail.
  - full blocks enq even if a resolve occurs in the same cycle; no bypass.
- Resolve accepted iff resolve && !empty. It reads entry[head] combinationally.
  - hit: entry[head].pred_pc == resolve_next_pc. Head increments, resolved_cnt += 1.
  - miss: the resolve is still counted (resolved_cnt += 1, mispred_cnt += 1). Next cycle: mispredict=1 and redirect_pc=resolve_next_pc. Queue is flushed in the same edge (head=tail=0, count=0).
  - entry[head].pc != resolve_pc sets order_err. Hit/miss is still evaluated on pred_pc.
- resolve && empty: sets order_err; no other state change.
- flush_now = ext_flush || (accepted resolve that misses).
  - On flush_now, a same-cycle enq is dropped.
  - ext_flush alone clears the queue; mispredict stays 0 and counters do not change.
  - If ext_flush coincides with a missing resolve: both counters still increment and mispredict still pulses.
- Count update: count_next = count + enq_acc − res_acc, except on flush_now, where count_next = 0. Simultaneous accepted enq and hit-resolve leaves count unchanged.
- mispredict is high for exactly one cycle per miss. Back-to-back misses are impossible because the queue is empty after a flush.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- full, empty and count are combinational from the registered count.
- Latency: enq → entry resolvable next cycle; miss resolve → mispredict/redirect 1 cycle later.

Test Plan:
- Reset with rst=0 mid-stream after 3 enqueues → count=0, empty=1, mispredict=0, counters=0 immediately, before the next clk edge.
- Enqueue pc 0x100, 0x104, 0x108 (pred pc+4); resolve each with next_pc=pc+4 → no mispredict, resolved_cnt=3, empty=1.
- Enqueue pc 0x200 with pred 0x204, plus 2 younger entries; resolve 0x200 with next_pc 0x300 → next cycle mispredict=1, redirect_pc=0x300, count=0, mispred_cnt=1; a same-cycle enq is dropped.
- Enqueue DEPTH=8 entries → full=1; 9th enq ignored; hold enq high while resolving head (hit) → that cycle's enq still rejected; next cycle count=7 and enq accepted; tail wraps 7→0 correctly.
- resolve with empty queue → order_err=1 and stays 1; resolve_pc 0x404 while head pc is 0x400 → order_err set, hit/miss decided on pred_pc.
- ext_flush with 5 entries plus a same-cycle enq → count=0, mispredict stays 0, counters unchanged.
